// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, generator state encoding and a length clamp helper.
package eth_pkg;

    localparam int ETH_HDR_BYTES = 14;
    localparam int IP_HDR_BYTES  = 20;
    localparam int UDP_HDR_BYTES = 8;
    localparam int HDR_BYTES     = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
    localparam int CSUM_WORDS    = IP_HDR_BYTES / 2;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CSUM    = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GAP     = 3'd4
    } gen_state_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input logic [15:0] min_len,
                                              input logic [15:0] max_len);
        if (len < min_len)
            return min_len;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/ipv4_checksum.sv
// Running ones-complement sum of 16-bit words; result is the inverted folded sum.
module ipv4_checksum (
    input  logic        clk,
    input  logic        sresetn,
    input  logic        clear,
    input  logic        valid,
    input  logic [15:0] word,
    output logic [15:0] result
);

    logic [15:0] acc;
    logic [16:0] sum;

    assign sum = {1'b0, acc} + {1'b0, word};

    // End-around carry folded every word, so acc never needs a final fold pass.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (valid)
            acc <= sum[15:0] + {15'd0, sum[16]};
    end

    assign result = ~acc;

endmodule

// File: rtl/udp_frame_gen.sv
// UDP/IPv4/Ethernet frame generator with AXI-Stream byte output.
// Optional macro UDP_FRAME_GEN_SEQNUM_EN puts a 32-bit sequence number in the first 4 payload bytes.
module udp_frame_gen
    import eth_pkg::*;
#(
    parameter int PAYLOAD_MAX = 1472,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        sresetn,
    input  logic        enable,
    input  logic [47:0] src_mac,
    input  logic [47:0] dst_mac,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    input  logic        pattern_mode,
    input  logic [7:0]  pattern_byte,
    input  logic        axis_o_tready,
    output logic        axis_o_tvalid,
    output logic        axis_o_tlast,
    output logic [7:0]  axis_o_tdata,
    output logic        busy,
    output logic [31:0] pkt_count
);

`ifdef UDP_FRAME_GEN_SEQNUM_EN
    localparam logic [15:0] LEN_MIN = 16'd4;
`else
    localparam logic [15:0] LEN_MIN = 16'd1;
`endif
    localparam logic [15:0] LEN_MAX  = 16'(PAYLOAD_MAX);
    localparam int          GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    gen_state_t  state;
    logic [15:0] cnt;
    logic [47:0] cfg_src_mac, cfg_dst_mac;
    logic [31:0] cfg_src_ip, cfg_dst_ip;
    logic [15:0] cfg_src_port, cfg_dst_port, cfg_len;
    logic        cfg_mode;
    logic [7:0]  cfg_byte;
    logic [15:0] ip_total, udp_len, csum_word, csum;
    logic [7:0]  hdr_byte, pay_byte;
    logic        handshake;

    assign ip_total  = 16'(IP_HDR_BYTES + UDP_HDR_BYTES) + cfg_len;
    assign udp_len   = 16'(UDP_HDR_BYTES) + cfg_len;
    assign handshake = axis_o_tvalid && axis_o_tready;

    always_comb begin
        case (cnt[3:0])
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = ip_total;
            4'd2:    csum_word = pkt_count[15:0];
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {8'h40, IP_PROTO_UDP};
            4'd6:    csum_word = cfg_src_ip[31:16];
            4'd7:    csum_word = cfg_src_ip[15:0];
            4'd8:    csum_word = cfg_dst_ip[31:16];
            4'd9:    csum_word = cfg_dst_ip[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    ipv4_checksum u_csum (
        .clk    (clk),
        .sresetn(sresetn),
        .clear  (state == ST_IDLE),
        .valid  (state == ST_CSUM),
        .word   (csum_word),
        .result (csum)
    );

    always_comb begin
        case (cnt[5:0])
            6'd0:    hdr_byte = cfg_dst_mac[47:40];
            6'd1:    hdr_byte = cfg_dst_mac[39:32];
            6'd2:    hdr_byte = cfg_dst_mac[31:24];
            6'd3:    hdr_byte = cfg_dst_mac[23:16];
            6'd4:    hdr_byte = cfg_dst_mac[15:8];
            6'd5:    hdr_byte = cfg_dst_mac[7:0];
            6'd6:    hdr_byte = cfg_src_mac[47:40];
            6'd7:    hdr_byte = cfg_src_mac[39:32];
            6'd8:    hdr_byte = cfg_src_mac[31:24];
            6'd9:    hdr_byte = cfg_src_mac[23:16];
            6'd10:   hdr_byte = cfg_src_mac[15:8];
            6'd11:   hdr_byte = cfg_src_mac[7:0];
            6'd12:   hdr_byte = ETHERTYPE_IPV4[15:8];
            6'd13:   hdr_byte = ETHERTYPE_IPV4[7:0];
            6'd14:   hdr_byte = 8'h45;
            6'd16:   hdr_byte = ip_total[15:8];
            6'd17:   hdr_byte = ip_total[7:0];
            6'd18:   hdr_byte = pkt_count[15:8];
            6'd19:   hdr_byte = pkt_count[7:0];
            6'd20:   hdr_byte = 8'h40;
            6'd22:   hdr_byte = 8'h40;
            6'd23:   hdr_byte = IP_PROTO_UDP;
            6'd24:   hdr_byte = csum[15:8];
            6'd25:   hdr_byte = csum[7:0];
            6'd26:   hdr_byte = cfg_src_ip[31:24];
            6'd27:   hdr_byte = cfg_src_ip[23:16];
            6'd28:   hdr_byte = cfg_src_ip[15:8];
            6'd29:   hdr_byte = cfg_src_ip[7:0];
            6'd30:   hdr_byte = cfg_dst_ip[31:24];
            6'd31:   hdr_byte = cfg_dst_ip[23:16];
            6'd32:   hdr_byte = cfg_dst_ip[15:8];
            6'd33:   hdr_byte = cfg_dst_ip[7:0];
            6'd34:   hdr_byte = cfg_src_port[15:8];
            6'd35:   hdr_byte = cfg_src_port[7:0];
            6'd36:   hdr_byte = cfg_dst_port[15:8];
            6'd37:   hdr_byte = cfg_dst_port[7:0];
            6'd38:   hdr_byte = udp_len[15:8];
            6'd39:   hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // pkt_count only moves on the tlast handshake, so it still holds the frame-start value here.
    always_comb begin
        pay_byte = cfg_mode ? cnt[7:0] : cfg_byte;
`ifdef UDP_FRAME_GEN_SEQNUM_EN
        if (cnt < 16'd4) begin
            case (cnt[1:0])
                2'd0:    pay_byte = pkt_count[31:24];
                2'd1:    pay_byte = pkt_count[23:16];
                2'd2:    pay_byte = pkt_count[15:8];
                default: pay_byte = pkt_count[7:0];
            endcase
        end
`endif
    end

    assign axis_o_tvalid = (state == ST_HDR) || (state == ST_PAYLOAD);
    assign axis_o_tlast  = (state == ST_PAYLOAD) && (cnt == cfg_len - 16'd1);
    assign axis_o_tdata  = (state == ST_HDR) ? hdr_byte :
                           (state == ST_PAYLOAD) ? pay_byte : 8'h00;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            pkt_count    <= '0;
            cfg_src_mac  <= '0;
            cfg_dst_mac  <= '0;
            cfg_src_ip   <= '0;
            cfg_dst_ip   <= '0;
            cfg_src_port <= '0;
            cfg_dst_port <= '0;
            cfg_len      <= LEN_MIN;
            cfg_mode     <= 1'b0;
            cfg_byte     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        cfg_src_mac  <= src_mac;
                        cfg_dst_mac  <= dst_mac;
                        cfg_src_ip   <= src_ip;
                        cfg_dst_ip   <= dst_ip;
                        cfg_src_port <= src_port;
                        cfg_dst_port <= dst_port;
                        cfg_len      <= clamp_len(payload_len, LEN_MIN, LEN_MAX);
                        cfg_mode     <= pattern_mode;
                        cfg_byte     <= pattern_byte;
                        cnt          <= '0;
                        state        <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (cnt == 16'(CSUM_WORDS - 1)) begin
                        cnt   <= '0;
                        state <= ST_HDR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_HDR: begin
                    if (handshake) begin
                        if (cnt == 16'(HDR_BYTES - 1)) begin
                            cnt   <= '0;
                            state <= ST_PAYLOAD;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (handshake) begin
                        if (axis_o_tlast) begin
                            pkt_count <= pkt_count + 32'd1;
                            cnt       <= '0;
                            state     <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == 16'(GAP_LAST)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_frame_gen.sv
// Directed self-checking bench for udp_frame_gen (default build, PAYLOAD_MAX=1472, GAP_CYCLES=16).
module tb_udp_frame_gen;

    logic        clk = 1'b0;
    logic        sresetn;
    logic        enable;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, payload_len;
    logic        pattern_mode;
    logic [7:0]  pattern_byte;
    logic        tready;
    logic        tvalid, tlast, busy;
    logic [7:0]  tdata;
    logic [31:0] pkt_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rx [2048];
    logic [7:0] exp_frame [2048];
    int exp_len;
    int nbytes, lead_idle, tlast_cnt, last_pos;

    udp_frame_gen #(.PAYLOAD_MAX(1472), .GAP_CYCLES(16)) dut (
        .clk          (clk),
        .sresetn      (sresetn),
        .enable       (enable),
        .src_mac      (src_mac),
        .dst_mac      (dst_mac),
        .src_ip       (src_ip),
        .dst_ip       (dst_ip),
        .src_port     (src_port),
        .dst_port     (dst_port),
        .payload_len  (payload_len),
        .pattern_mode (pattern_mode),
        .pattern_byte (pattern_byte),
        .axis_o_tready(tready),
        .axis_o_tvalid(tvalid),
        .axis_o_tlast (tlast),
        .axis_o_tdata (tdata),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference frame built from the current bench-side config, independent of DUT internals.
    task automatic build_expected(input logic [15:0] id, input int len);
        logic [15:0] tot, ul, ck;
        logic [31:0] s;
        logic [15:0] w [10];
        logic [335:0] hdr;
        tot = 16'(28 + len);
        ul  = 16'(8 + len);
        w = '{16'h4500, tot, id, 16'h4000, 16'h4011, 16'h0000,
              src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0]};
        s = 32'd0;
        for (int i = 0; i < 10; i++) s = s + {16'd0, w[i]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        ck = ~s[15:0];
        hdr = {dst_mac, src_mac, 16'h0800, 8'h45, 8'h00, tot, id, 16'h4000, 8'h40, 8'h11,
               ck, src_ip, dst_ip, src_port, dst_port, ul, 16'h0000};
        for (int i = 0; i < 42; i++) exp_frame[i] = hdr[335 - 8*i -: 8];
        for (int i = 0; i < len; i++) exp_frame[42 + i] = pattern_mode ? 8'(i) : pattern_byte;
        exp_len = 42 + len;
    endtask

    task automatic compare_model(input string tag);
        int mism = 0;
        for (int i = 0; i < exp_len; i++) if (rx[i] !== exp_frame[i]) mism++;
        check_output({tag, "_bytes"}, 32'(mism), 32'd0);
        check_output({tag, "_len"}, 32'(nbytes), 32'(exp_len));
    endtask

    task automatic start_frame();
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic capture(input bit throttle, input int drop_en_at, input int stop_at);
        bit done = 0, stalled = 0, held_last = 0;
        logic [7:0] held_data = 8'h00;
        nbytes = 0; lead_idle = 0; tlast_cnt = 0; last_pos = -1;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            @(posedge clk); #1;
            if (stalled) begin
                check_output("stall_tdata", {24'd0, tdata}, {24'd0, held_data});
                check_output("stall_tlast", {31'd0, tlast}, {31'd0, held_last});
            end
            stalled = 0;
            tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!tvalid) begin
                if (nbytes == 0) lead_idle++;
            end else if (tready) begin
                rx[nbytes] = tdata;
                if (tlast) begin
                    tlast_cnt++;
                    last_pos = nbytes;
                    done = 1;
                end
                nbytes++;
                if (nbytes == drop_en_at) enable = 1'b0;
                if (nbytes == stop_at) done = 1;
            end else begin
                stalled = 1;
                held_data = tdata;
                held_last = tlast;
            end
        end
        if (!done) check_output("capture_timeout", 32'd0, 32'd1);
        tready = 1'b1;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check_output("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen_valid;
        sresetn = 1'b0; enable = 1'b0; tready = 1'b1;
        dst_mac = 48'h0011_2233_4455; src_mac = 48'h66AA_BBCC_DDEE;
        src_ip = 32'hC0A8_0001; dst_ip = 32'hC0A8_0002;
        src_port = 16'h1234; dst_port = 16'h5678;
        payload_len = 16'd1; pattern_mode = 1'b0; pattern_byte = 8'h5A;

        #3;
        check_output("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_output("rst_tlast", {31'd0, tlast}, 32'd0);
        check_output("rst_tdata", {24'd0, tdata}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_pkt_count", pkt_count, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        sresetn = 1'b1;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        check_output("idle_no_enable_busy", {31'd0, busy}, 32'd0);
        check_output("idle_no_enable_tvalid", {31'd0, tvalid}, 32'd0);

        // Frame 0: len 1, config scrambled after latching must not leak in.
        build_expected(16'd0, 1);
        start_frame();
        src_ip = 32'hDEAD_BEEF; dst_mac = 48'hFFFF_FFFF_FFFF; payload_len = 16'd99; pattern_byte = 8'h00;
        capture(0, 0, 0);
        check_output("f0_nbytes", 32'(nbytes), 32'd43);
        check_output("f0_tlast_pos", 32'(last_pos), 32'd42);
        check_output("f0_tlast_cnt", 32'(tlast_cnt), 32'd1);
        check_output("f0_csum_hi", {24'd0, rx[24]}, 32'hB9);
        check_output("f0_csum_lo", {24'd0, rx[25]}, 32'h7C);
        check_output("f0_totlen", {16'd0, rx[16], rx[17]}, 32'h001D);
        check_output("f0_udplen", {16'd0, rx[38], rx[39]}, 32'h0009);
        check_output("f0_payload", {24'd0, rx[42]}, 32'h5A);
        compare_model("f0");
        wait_idle();
        check_output("f0_pkt_count", pkt_count, 32'd1);

        src_ip = 32'hC0A8_0001; dst_mac = 48'h0011_2233_4455;

        // Frame 1: len 0 clamps up to 1.
        payload_len = 16'd0; pattern_byte = 8'h11;
        build_expected(16'd1, 1);
        start_frame();
        capture(0, 0, 0);
        check_output("f1_nbytes", 32'(nbytes), 32'd43);
        compare_model("f1");
        wait_idle();

        // Frame 2: len 2000 clamps down to 1472.
        payload_len = 16'd2000; pattern_byte = 8'h33;
        build_expected(16'd2, 1472);
        start_frame();
        capture(0, 0, 0);
        check_output("f2_nbytes", 32'(nbytes), 32'd1514);
        check_output("f2_totlen", {16'd0, rx[16], rx[17]}, 32'h05DC);
        check_output("f2_udplen", {16'd0, rx[38], rx[39]}, 32'h05C8);
        compare_model("f2");
        wait_idle();

        // Frame 3: incrementing, len 300 wraps after 0xFF.
        payload_len = 16'd300; pattern_mode = 1'b1;
        build_expected(16'd3, 300);
        start_frame();
        capture(0, 0, 0);
        check_output("f3_byte255", {24'd0, rx[42 + 255]}, 32'hFF);
        check_output("f3_byte256", {24'd0, rx[42 + 256]}, 32'h00);
        check_output("f3_lastbyte", {24'd0, rx[341]}, 32'h2B);
        compare_model("f3");
        wait_idle();

        // Frame 4: constant 0xA5.
        payload_len = 16'd20; pattern_mode = 1'b0; pattern_byte = 8'hA5;
        build_expected(16'd4, 20);
        start_frame();
        capture(0, 0, 0);
        check_output("f4_byte60", {24'd0, rx[60]}, 32'hA5);
        compare_model("f4");
        wait_idle();

        // Frame 5: incrementing len 300 under random back-pressure.
        payload_len = 16'd300; pattern_mode = 1'b1;
        build_expected(16'd5, 300);
        start_frame();
        capture(1, 0, 0);
        check_output("f5_tlast_cnt", 32'(tlast_cnt), 32'd1);
        compare_model("f5");
        wait_idle();

        // Frames 6/7: back-to-back, then enable drops mid-payload of frame 7.
        payload_len = 16'd5; pattern_mode = 1'b0; pattern_byte = 8'hC3;
        enable = 1'b1;
        build_expected(16'd6, 5);
        capture(0, 0, 0);
        compare_model("f6");
        build_expected(16'd7, 5);
        capture(0, 44, 0);
        check_output("f7_gap_cycles", 32'(lead_idle), 32'd27);
        compare_model("f7");
        seen_valid = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (tvalid) seen_valid++;
        end
        check_output("no_frame_after_drop", 32'(seen_valid), 32'd0);
        check_output("idle_after_drop", {31'd0, busy}, 32'd0);
        check_output("f7_pkt_count", pkt_count, 32'd8);

        // Frame 8: async reset at payload byte 5.
        payload_len = 16'd20; pattern_byte = 8'h3C;
        start_frame();
        capture(0, 0, 47);
        check_output("pre_rst_tvalid", {31'd0, tvalid}, 32'd1);
        #1 sresetn = 1'b0;
        #1;
        check_output("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check_output("mid_rst_tlast", {31'd0, tlast}, 32'd0);
        check_output("mid_rst_tdata", {24'd0, tdata}, 32'd0);
        check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_output("mid_rst_pkt_count", pkt_count, 32'd0);
        @(posedge clk); #1;
        sresetn = 1'b1;
        build_expected(16'd0, 20);
        start_frame();
        capture(0, 0, 0);
        check_output("post_rst_byte0", {24'd0, rx[0]}, 32'h00);
        check_output("post_rst_byte5", {24'd0, rx[5]}, 32'h55);
        compare_model("post_rst");
        wait_idle();
        check_output("post_rst_pkt_count", pkt_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/udp_frame_gen.md
UDP_FRAME_GEN -- requirements
Module: udp_frame_gen

Interface
REQ-001 SHALL have parameter PAYLOAD_MAX, default 1472, meaning maximum UDP payload bytes per frame.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning idle clocks inserted after each frame's tlast handshake.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port sresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  input  1  start/continue frame generation.
REQ-006 SHALL have ports src_mac/dst_mac  input  48 each  Ethernet addresses.
REQ-007 SHALL have ports src_ip/dst_ip  input  32 each  IPv4 addresses.
REQ-008 SHALL have ports src_port/dst_port  input  16 each  UDP ports.
REQ-009 SHALL have port payload_len  input  16  requested payload bytes.
REQ-010 SHALL have port pattern_mode  input  1  0 = constant, 1 = incrementing payload.
REQ-011 SHALL have port pattern_byte  input  8  constant-mode byte value.
REQ-012 SHALL have ports axis_o_tready (in 1), axis_o_tvalid (out 1), axis_o_tlast (out 1), axis_o_tdata (out 8)  frame output stream.
REQ-013 SHALL have ports busy  output  1  (high when not IDLE) and pkt_count  output  32  (completed frames).

Function
REQ-014 SHALL implement states IDLE, CSUM, HDR, PAYLOAD, GAP.
REQ-015 SHALL, in IDLE with enable=1, latch all config inputs and enter CSUM next cycle; config changes after latching SHALL NOT affect the frame in flight.
REQ-016 SHALL clamp latched payload_len: 0 -> 1, above PAYLOAD_MAX -> PAYLOAD_MAX.
REQ-017 SHALL spend exactly 10 cycles in CSUM: one IPv4 header word per cycle, ones-complement sum, carries folded, result inverted.
REQ-018 SHALL emit 42 header bytes in HDR, MSB-first per field: dst_mac, src_mac, 0x0800, 0x45, 0x00, total length (28+len), ID = pkt_count[15:0], 0x4000, TTL 0x40, protocol 0x11, checksum, src_ip, dst_ip, src_port, dst_port, UDP length (8+len), UDP checksum 0x0000.
REQ-019 SHALL emit len payload bytes in PAYLOAD: constant mode = pattern_byte; incrementing mode = 0x00, 0x01, ..., wrapping 0xFF -> 0x00.
REQ-020 SHALL assert tlast only on the final payload byte.
REQ-021 SHALL hold tvalid high continuously in HDR and PAYLOAD; tvalid low in IDLE, CSUM, GAP.
REQ-022 SHALL hold tdata/tlast stable while tvalid=1 and tready=0; advance only on tvalid&tready.
REQ-023 SHALL increment pkt_count (wrap 0xFFFFFFFF -> 0) on the tlast handshake and enter GAP.
REQ-024 SHALL stay in GAP exactly GAP_CYCLES cycles (GAP_CYCLES=0: direct to IDLE), then IDLE; back-to-back frames if enable still 1.
REQ-025 SHALL complete a frame already started when enable drops mid-frame; no truncation.

Reset
REQ-026 SHALL on sresetn=0 immediately force state IDLE, tvalid=0, tlast=0, tdata=0x00, busy=0, pkt_count=0, sequence counter 0, regardless of frame in flight.
REQ-027 SHALL after reset release start no frame before the first clock edge with enable=1 sampled in IDLE.

Configuration
REQ-028 SHALL support macro UDP_FRAME_GEN_SEQNUM_EN: defined -> first 4 payload bytes replaced by a 32-bit sequence number (MSB-first, value = pkt_count at frame start) and minimum clamped len becomes 4; undefined -> payload purely per REQ-019, no sequence logic synthesised.

Structure
REQ-029 SHALL take from shared package eth_pkg: ETH_HDR_BYTES=14, IP_HDR_BYTES=20, UDP_HDR_BYTES=8, ETHERTYPE_IPV4=0x0800, IP_PROTO_UDP=17, state enum typedef.
REQ-030 SHALL place checksum accumulation in sub-module ipv4_checksum (16-bit word in, clear/valid, 16-bit result).

Verification
REQ-031 SHALL verify: src 192.168.0.1, dst 192.168.0.2, len 1, pkt_count 0 -> header checksum bytes 0xB9 0x7C, total length 0x001D, UDP length 0x0009, 43 bytes, tlast on byte 43.
REQ-032 SHALL verify: len 0 -> exactly 1 payload byte; len 2000 with PAYLOAD_MAX 1472 -> 1514-byte frame.
REQ-033 SHALL verify: incrementing mode, len 300 -> payload 0x00..0xFF, 0x00..0x2B; constant 0xA5 -> all 0xA5.
REQ-034 SHALL verify: random tready throttling (50%) -> byte stream identical to tready=1 run; tdata stable during stalls.
REQ-035 SHALL verify: enable held 1, GAP_CYCLES 16 -> exactly 16+10+1 non-valid cycles between tlast and next frame's first byte; enable dropped mid-payload -> frame completes, no next frame.
REQ-036 SHALL verify: sresetn asserted at payload byte 5 -> tvalid 0 same cycle without clock edge, pkt_count 0, next frame starts with header byte 0.
